countdown_ctrl: RTL

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

---
 rtl/countdown_ctrl_pkg.sv | 22 ++
 rtl/countdown_ctrl_sec_tick_gen.sv | 31 +++
 rtl/countdown_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/countdown_ctrl_pkg.sv
// Shared game definitions: countdown FSM state encoding and BCD digit limits.
// Also used by the top-level video mux and the game FSM.
package countdown_ctrl_pkg;

  // Countdown FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_GO    = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  // A single on-screen BCD digit.
  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MIN = 4'd0;
  localparam bcd_t DIGIT_MAX = 4'd9;

  // The countdown screen is visible while counting and while holding the 0.
  function automatic logic is_show_state(input logic [1:0] st);
    return (st == ST_COUNT) || (st == ST_GO);
  endfunction

endpackage

// File: rtl/countdown_ctrl_sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 and raises tick for the single
// cycle in which the count sits at its terminal value.
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int              W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0]    TERM = W'(CLK_HZ - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == TERM);

  // Free-running count that wraps after the terminal value; clr restarts it.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Pre-game countdown controller: shows START_SEC..1 then holds 0 for GO_SEC
// seconds, then enables gameplay. The digit and screen select shown to the
// video path only change at frame_start so a frame is never torn.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int START_SEC = 3,  // legal 1..9
  parameter int GO_SEC    = 1   // legal 1..9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       frame_start,
  output logic [3:0] sec_1s,
  output logic       show_countdown,
  output logic       game_en,
  output logic       done
);

  localparam bcd_t START_DIGIT = (START_SEC > int'(DIGIT_MAX)) ? DIGIT_MAX : bcd_t'(START_SEC);
  localparam bcd_t GO_LAST     = bcd_t'(GO_SEC - 1);

  logic [1:0] state;
  bcd_t       count;
  bcd_t       go_cnt;
  logic       tick;
  logic       clr;
  logic       show_level;
  logic       count_last;

  assign count_last = (count == 4'd1);
  assign show_level = is_show_state(state);

  // Prescaler restart: held clear in IDLE, on abort, and when COUNT hands over to GO.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    clr = 1'b0;
    if (abort || (state == ST_IDLE)) begin
      clr = 1'b1;
    end else if ((state == ST_COUNT) && tick && count_last) begin
      clr = 1'b1;
    end
  end

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  // Countdown FSM with game_en level and done pulse; abort has top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= DIGIT_MIN;
      go_cnt  <= DIGIT_MIN;
      game_en <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= ST_IDLE;
        count   <= DIGIT_MIN;
        go_cnt  <= DIGIT_MIN;
        game_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_COUNT;
              count <= START_DIGIT;
            end
          end
          ST_COUNT: begin
            if (tick) begin
              if (count_last) begin
                state  <= ST_GO;
                count  <= DIGIT_MIN;
                go_cnt <= DIGIT_MIN;
              end else begin
                count <= count - 4'd1;
              end
            end
          end
          ST_GO: begin
            if (tick) begin
              if (go_cnt == GO_LAST) begin
                state   <= ST_RUN;
                game_en <= 1'b1;
                done    <= 1'b1;
              end else begin
                go_cnt <= go_cnt + 4'd1;
              end
            end
          end
          ST_RUN: begin
            game_en <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Frame-synchronous copy of the digit and screen select for the video path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_1s         <= DIGIT_MIN;
      show_countdown <= 1'b0;
    end else if (frame_start) begin
      sec_1s         <= count;
      show_countdown <= show_level;
    end
  end

endmodule
